// File: rtl/config_pkg.sv
// Shared types for the ALU packet parser: opcodes, parser states and header size.
package config_pkg;

    typedef enum logic [7:0] {
        OP_ECHO = 8'hEC,
        OP_ADD  = 8'hAD,
        OP_MUL  = 8'h88,
        OP_DIV  = 8'h99
    } opcode_e;

    localparam int unsigned HEADER_BYTES = 4;

    typedef enum logic [2:0] {
        ST_OPCODE,
        ST_RSVD,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_CMD,
        ST_ECHO,
        ST_OPERAND,
        ST_DRAIN
    } parser_state_e;

    function automatic logic is_known_opcode(input logic [7:0] op);
        return (op == OP_ECHO) || (op == OP_ADD) || (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic logic is_arith_opcode(input logic [7:0] op);
        return (op == OP_ADD) || (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_packet_parser.sv
// Byte-stream packet decoder feeding the ALU: header decode, echo pass-through, operand assembly.
// Optional inter-byte idle timeout is enabled by defining ALU_PARSER_TIMEOUT_EN.
//
// state      | meaning
// OPCODE     | waiting for the opcode byte
// RSVD       | reserved byte, value ignored
// LEN_LO     | low byte of total length
// LEN_HI     | high byte of total length; header validated on accept
// CMD        | presenting opcode/length downstream
// ECHO       | payload bytes passed straight through
// OPERAND    | payload packed into 32-bit little-endian words
// DRAIN      | discarding payload of a rejected packet
module alu_packet_parser
    import config_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 12_000_000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [7:0]  cmd_o,
    output logic [15:0] len_o,
    output logic        cmd_valid_o,
    input  logic        cmd_ready_i,
    output logic [7:0]  echo_data_o,
    output logic        echo_valid_o,
    input  logic        echo_ready_i,
    output logic [31:0] operand_o,
    output logic        operand_last_o,
    output logic        operand_valid_o,
    input  logic        operand_ready_i,
    output logic        err_o
);

    localparam logic [15:0] HDR_LEN = 16'(HEADER_BYTES);

    if (TimeoutCycles == 0) begin : g_timeout_check
        $error("TimeoutCycles must be nonzero");
    end

    parser_state_e r_state;
    parser_state_e w_state_next;

    logic [7:0]  r_opcode;
    logic [15:0] r_len;
    logic [15:0] r_remaining;
    logic [31:0] r_operand;
    logic [1:0]  r_byte_cnt;
    logic        r_operand_valid;
    logic        r_operand_last;
    logic        r_err;

    logic        w_rx_fire;
    logic [15:0] w_len_full;
    logic [15:0] w_payload;
    logic        w_hdr_short;
    logic        w_hdr_arith_bad;
    logic        w_hdr_err;
    logic        w_last_byte;
    logic        w_op_stall;
    logic        w_op_accept;
    logic        w_timeout;

    assign w_rx_fire   = rx_valid_i && rx_ready_o;
    assign w_len_full  = {rx_data_i, r_len[7:0]};
    assign w_payload   = w_len_full - HDR_LEN;
    assign w_hdr_short = w_len_full < HDR_LEN;
    assign w_hdr_arith_bad = is_arith_opcode(r_opcode) &&
                             ((w_payload < 16'd8) || (w_payload[1:0] != 2'b00));
    assign w_hdr_err   = w_hdr_short || !is_known_opcode(r_opcode) || w_hdr_arith_bad;
    assign w_last_byte = (r_remaining == 16'd1);
    assign w_op_stall  = r_operand_valid && !operand_ready_i;
    assign w_op_accept = r_operand_valid && operand_ready_i;

`ifdef ALU_PARSER_TIMEOUT_EN
    localparam logic [31:0] IDLE_LIMIT = 32'(TimeoutCycles - 1);

    logic [31:0] r_idle_cnt;
    logic        w_idle_active;
    logic        w_down_stall;

    // A stalled downstream consumer is not an idle upstream, so the count pauses.
    assign w_down_stall  = (echo_valid_o && !echo_ready_i) || w_op_stall;
    assign w_idle_active = (r_state != ST_OPCODE) && (r_state != ST_CMD);
    assign w_timeout     = w_idle_active && !w_rx_fire && !w_down_stall &&
                           (r_idle_cnt == IDLE_LIMIT);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_idle_cnt <= '0;
        end else if (!w_idle_active || w_rx_fire || w_timeout) begin
            r_idle_cnt <= '0;
        end else if (!w_down_stall) begin
            r_idle_cnt <= r_idle_cnt + 32'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_OPCODE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_timeout) begin
            w_state_next = ST_OPCODE;
        end else begin
            case (r_state)
                ST_OPCODE:  if (w_rx_fire) w_state_next = ST_RSVD;
                ST_RSVD:    if (w_rx_fire) w_state_next = ST_LEN_LO;
                ST_LEN_LO:  if (w_rx_fire) w_state_next = ST_LEN_HI;
                ST_LEN_HI: begin
                    if (w_rx_fire) begin
                        if (w_hdr_short || (w_payload == 16'd0 && w_hdr_err)) begin
                            w_state_next = ST_OPCODE;
                        end else if (w_hdr_err) begin
                            w_state_next = ST_DRAIN;
                        end else begin
                            w_state_next = ST_CMD;
                        end
                    end
                end
                ST_CMD: begin
                    if (cmd_ready_i) begin
                        if (r_remaining == 16'd0) begin
                            w_state_next = ST_OPCODE;
                        end else if (r_opcode == OP_ECHO) begin
                            w_state_next = ST_ECHO;
                        end else begin
                            w_state_next = ST_OPERAND;
                        end
                    end
                end
                ST_ECHO:    if (w_rx_fire && w_last_byte) w_state_next = ST_OPCODE;
                ST_OPERAND: if (w_op_accept && r_operand_last) w_state_next = ST_OPCODE;
                ST_DRAIN:   if (w_rx_fire && w_last_byte) w_state_next = ST_OPCODE;
                default:    w_state_next = ST_OPCODE;
            endcase
        end
    end

    always_comb begin
        rx_ready_o   = 1'b0;
        cmd_valid_o  = 1'b0;
        echo_valid_o = 1'b0;
        case (r_state)
            ST_OPCODE, ST_RSVD, ST_LEN_LO, ST_LEN_HI: rx_ready_o = 1'b1;
            ST_CMD:     cmd_valid_o = 1'b1;
            ST_ECHO: begin
                echo_valid_o = rx_valid_i;
                rx_ready_o   = echo_ready_i;
            end
            // Once the final byte is in, hold off the next packet until the last word leaves.
            ST_OPERAND: rx_ready_o = (r_remaining != 16'd0) && !w_op_stall;
            ST_DRAIN:   rx_ready_o = 1'b1;
            default:    rx_ready_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_opcode        <= '0;
            r_len           <= '0;
            r_remaining     <= '0;
            r_operand       <= '0;
            r_byte_cnt      <= '0;
            r_operand_valid <= 1'b0;
            r_operand_last  <= 1'b0;
            r_err           <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (w_timeout) begin
                r_err           <= 1'b1;
                r_operand_valid <= 1'b0;
                r_operand_last  <= 1'b0;
                r_byte_cnt      <= '0;
                r_remaining     <= '0;
            end else begin
                if (w_op_accept) begin
                    r_operand_valid <= 1'b0;
                    r_operand_last  <= 1'b0;
                end
                case (r_state)
                    ST_OPCODE: if (w_rx_fire) r_opcode <= rx_data_i;
                    ST_LEN_LO: if (w_rx_fire) r_len[7:0] <= rx_data_i;
                    ST_LEN_HI: begin
                        if (w_rx_fire) begin
                            r_len[15:8] <= rx_data_i;
                            r_byte_cnt  <= '0;
                            r_err       <= w_hdr_err;
                            r_remaining <= w_hdr_short ? 16'd0 : w_payload;
                        end
                    end
                    ST_ECHO, ST_DRAIN: begin
                        if (w_rx_fire) r_remaining <= r_remaining - 16'd1;
                    end
                    ST_OPERAND: begin
                        if (w_rx_fire) begin
                            r_operand   <= {rx_data_i, r_operand[31:8]};
                            r_byte_cnt  <= r_byte_cnt + 2'd1;
                            r_remaining <= r_remaining - 16'd1;
                            if (r_byte_cnt == 2'd3) begin
                                r_operand_valid <= 1'b1;
                                r_operand_last  <= w_last_byte;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign cmd_o           = r_opcode;
    assign len_o           = r_len;
    assign echo_data_o     = rx_data_i;
    assign operand_o       = r_operand;
    assign operand_valid_o = r_operand_valid;
    assign operand_last_o  = r_operand_last;
    assign err_o           = r_err;

endmodule
